// File: rtl/onehot_pkg.sv
// ============================================================================
// Module      : onehot_pkg
// Description : Shared mode constants and width helpers for the pipelined
//               one-hot to binary encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_pkg;

   localparam int MODE_STRICT = 0;
   localparam int MODE_LSB    = 1;
   localparam int MODE_MSB    = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // An index always needs at least one bit, even for a single-entry range.
   function automatic int dout_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_group_enc.sv
// ============================================================================
// Module      : onehot_group_enc
// Description : Combinational encoder for one group of the select vector:
//               local index (strict/LSB/MSB), any-set and multi-set flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_group_enc
   import onehot_pkg::*;
#(
   parameter int GROUP_W = 4,
   parameter int MODE    = MODE_STRICT,
   parameter int IDX_W   = dout_width(GROUP_W)
) (
   input  logic [GROUP_W-1:0] i_vec,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any,
   output logic               o_multi
);

   always_comb begin
      o_idx   = '0;
      o_any   = 1'b0;
      o_multi = 1'b0;
      for (int i = 0; i < GROUP_W; i++) begin
         if (i_vec[i]) begin
            // o_any still reflects lower bits only, so it flags a second hit.
            o_multi = o_multi | o_any;
            if (MODE == MODE_STRICT) begin
               o_idx = o_idx | IDX_W'(i);
            end else if (MODE == MODE_MSB) begin
               o_idx = IDX_W'(i);
            end else if (!o_any) begin
               o_idx = IDX_W'(i);
            end
            o_any = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/onehot_to_binary_pipe.sv
// ============================================================================
// Module      : onehot_to_binary_pipe
// Description : Two-stage valid/ready pipelined one-hot to binary encoder with
//               strict, LSB-priority and MSB-priority modes and hit/err flags.
//               Optional saturating error counter: ONEHOT_TO_BINARY_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_binary_pipe
   import onehot_pkg::*;
#(
   parameter int DIN_WIDTH  = 16,
   parameter int DOUT_WIDTH = dout_width(DIN_WIDTH),
   parameter int GROUPS     = 4,
   parameter int MODE       = MODE_STRICT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [DIN_WIDTH-1:0]  in_vec,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [DOUT_WIDTH-1:0] out_bin,
   output logic                  out_hit,
   output logic                  out_err
`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
   ,
   input  logic                  err_cnt_clr,
   output logic [7:0]            err_cnt
`endif
);

   localparam int GROUP_W = DIN_WIDTH / GROUPS;
   localparam int LW      = dout_width(GROUP_W);

   logic [GROUPS-1:0][LW-1:0] w_idx;
   logic [GROUPS-1:0]         w_any;
   logic [GROUPS-1:0]         w_multi;

   logic                      r_s1_vld;
   logic [GROUPS-1:0][LW-1:0] r_s1_idx;
   logic [GROUPS-1:0]         r_s1_any;
   logic [GROUPS-1:0]         r_s1_multi;

   logic                      r_out_vld;
   logic [DOUT_WIDTH-1:0]     r_out_bin;
   logic                      r_out_hit;
   logic                      r_out_err;

   logic                      w_s2_adv;
   logic [DOUT_WIDTH-1:0]     w_bin;
   logic                      w_hit;
   logic                      w_err;

   assign w_s2_adv = !r_out_vld | out_rdy;
   assign in_rdy   = !r_s1_vld | w_s2_adv;

   generate
      for (genvar g = 0; g < GROUPS; g++) begin : g_grp
         onehot_group_enc #(
            .GROUP_W (GROUP_W),
            .MODE    (MODE),
            .IDX_W   (LW)
         ) u_enc (
            .i_vec   (in_vec[g*GROUP_W +: GROUP_W]),
            .o_idx   (w_idx[g]),
            .o_any   (w_any[g]),
            .o_multi (w_multi[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_idx   <= '0;
         r_s1_any   <= '0;
         r_s1_multi <= '0;
      end else if (in_rdy) begin
         r_s1_vld <= in_vld;
         if (in_vld) begin
            r_s1_idx   <= w_idx;
            r_s1_any   <= w_any;
            r_s1_multi <= w_multi;
         end
      end
   end

   // w_hit doubles as "an earlier group already hit" while scanning upward.
   always_comb begin
      w_bin = '0;
      w_hit = 1'b0;
      w_err = 1'b0;
      for (int g = 0; g < GROUPS; g++) begin
         if (r_s1_any[g]) begin
            w_err = w_err | w_hit | r_s1_multi[g];
            if (MODE == MODE_STRICT) begin
               w_bin = w_bin | (DOUT_WIDTH'(g * GROUP_W) + DOUT_WIDTH'(r_s1_idx[g]));
            end else if (MODE == MODE_MSB) begin
               w_bin = DOUT_WIDTH'(g * GROUP_W) + DOUT_WIDTH'(r_s1_idx[g]);
            end else if (!w_hit) begin
               w_bin = DOUT_WIDTH'(g * GROUP_W) + DOUT_WIDTH'(r_s1_idx[g]);
            end
            w_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_out_bin <= '0;
         r_out_hit <= 1'b0;
         r_out_err <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_out_bin <= w_bin;
            r_out_hit <= w_hit;
            r_out_err <= w_err;
         end
      end
   end

   assign out_vld = r_out_vld;
   assign out_bin = r_out_bin;
   assign out_hit = r_out_hit;
   assign out_err = r_out_err;

`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= 8'd0;
      end else if (err_cnt_clr) begin
         r_err_cnt <= 8'd0;
      end else if (r_out_vld && out_rdy && r_out_err && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_onehot_to_binary_pipe.sv
// ============================================================================
// Module      : tb_onehot_to_binary_pipe
// Description : Scoreboard bench driving three encoder instances (strict, LSB,
//               MSB) from one stimulus stream. Covers ONEHOT_TO_BINARY_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_to_binary_pipe;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        in_vld  = 1'b0;
   logic        out_rdy = 1'b0;
   logic [15:0] in_vec  = '0;

   logic        rdy_o [3];
   logic        vld_o [3];
   logic        hit_o [3];
   logic        err_o [3];
   logic [3:0]  bin_o [3];
`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
   logic        err_cnt_clr = 1'b0;
   logic [7:0]  cnt_o [3];
`endif

   always #5 clk = ~clk;

   generate
      for (genvar m = 0; m < 3; m++) begin : g_dut
         onehot_to_binary_pipe #(
            .DIN_WIDTH (16),
            .GROUPS    (4),
            .MODE      (m)
         ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_vld      (in_vld),
            .in_rdy      (rdy_o[m]),
            .in_vec      (in_vec),
            .out_vld     (vld_o[m]),
            .out_rdy     (out_rdy),
            .out_bin     (bin_o[m]),
            .out_hit     (hit_o[m]),
            .out_err     (err_o[m])
`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
            ,
            .err_cnt_clr (err_cnt_clr),
            .err_cnt     (cnt_o[m])
`endif
         );
      end
   endgenerate

   typedef struct {
      logic [15:0] vec;
      int          t;
   } sb_t;

   sb_t        sb [$];
   int         checks   = 0;
   int         failures = 0;
   int         tnow     = 0;
   bit         lat_chk  = 1'b0;
   bit         stalled_prev = 1'b0;
   logic [3:0] held_bin [3];
   logic       held_hit [3];
   logic       held_err [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference: scans the whole vector, no notion of groups.
   task automatic ref_enc(input logic [15:0] v, input int mode,
                          output logic [3:0] b, output logic h, output logic e);
      int n;
      n = 0;
      b = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) begin
            n++;
            if (mode == 0)      b = b | 4'(i);
            else if (mode == 2) b = 4'(i);
            else if (n == 1)    b = 4'(i);
         end
      end
      h = (n > 0);
      e = (n > 1);
   endtask

   task automatic tick();
      logic       acc;
      logic       otx;
      logic [3:0] eb;
      logic       eh;
      logic       ee;
      sb_t        item;
      #1;
      acc = in_vld & rdy_o[0];
      otx = vld_o[0] & out_rdy;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("in_rdy_m%0d", m), rdy_o[m], (sb.size() < 2) || out_rdy);
         if (sb.size() == 0) chk($sformatf("spurious_vld_m%0d", m), vld_o[m], 0);
         if (stalled_prev) begin
            chk($sformatf("stall_vld_m%0d", m), vld_o[m], 1);
            chk($sformatf("stall_bin_m%0d", m), bin_o[m], held_bin[m]);
            chk($sformatf("stall_hit_m%0d", m), hit_o[m], held_hit[m]);
            chk($sformatf("stall_err_m%0d", m), err_o[m], held_err[m]);
         end
      end
      if (otx) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
         end else begin
            item = sb.pop_front();
            if (lat_chk) chk("latency", tnow - item.t, 2);
            for (int m = 0; m < 3; m++) begin
               ref_enc(item.vec, m, eb, eh, ee);
               chk($sformatf("bin_m%0d_v%04h", m, item.vec), bin_o[m], eb);
               chk($sformatf("hit_m%0d_v%04h", m, item.vec), hit_o[m], eh);
               chk($sformatf("err_m%0d_v%04h", m, item.vec), err_o[m], ee);
            end
         end
      end
      if (acc) sb.push_back('{vec: in_vec, t: tnow});
      stalled_prev = vld_o[0] & !out_rdy;
      for (int m = 0; m < 3; m++) begin
         held_bin[m] = bin_o[m];
         held_hit[m] = hit_o[m];
         held_err[m] = err_o[m];
      end
      @(posedge clk);
      tnow++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 12 && sb.size() > 0; k++) tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("rst_vld_m%0d", m), vld_o[m], 0);
         chk($sformatf("rst_bin_m%0d", m), bin_o[m], 0);
         chk($sformatf("rst_hit_m%0d", m), hit_o[m], 0);
         chk($sformatf("rst_err_m%0d", m), err_o[m], 0);
         chk($sformatf("rst_rdy_m%0d", m), rdy_o[m], 1);
`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
         chk($sformatf("rst_cnt_m%0d", m), cnt_o[m], 0);
`endif
      end
      @(negedge clk);

      // One-hot sweep, back to back with the consumer always ready
      lat_chk = 1'b1;
      out_rdy = 1'b1;
      in_vld  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_vec = 16'(1 << i);
         tick();
      end
      in_vld = 1'b0;
      drain();

      // Zero-hot, merged multi-hot, and the three-way priority vector
      in_vld = 1'b1;
      in_vec = 16'h0000; tick();
      in_vec = 16'h0006; tick();
      in_vec = 16'h8120; tick();
      in_vld = 1'b0;
      drain();

      // Payload ignored while not valid
      in_vec = 'x;
      repeat (3) tick();

      // Fill both stages against a stalled consumer, then release
      lat_chk = 1'b0;
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_vec = 16'(1 << (k + 2));
         tick();
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      drain();

      // Random traffic with ~40% consumer stalls
      in_vld = 1'b1;
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 3))
            0:       in_vec = 16'(1 << $urandom_range(0, 15));
            1:       in_vec = 16'h0000;
            default: in_vec = 16'($urandom);
         endcase
         out_rdy = ($urandom_range(0, 9) >= 4);
         tick();
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      drain();

      // Reset with two vectors in flight
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      in_vec  = 16'h0003; tick();
      in_vec  = 16'h0300; tick();
      rst_n  = 1'b0;
      in_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      stalled_prev = 1'b0;
      out_rdy = 1'b1;
      repeat (3) tick();
      lat_chk = 1'b1;
      in_vld  = 1'b1;
      in_vec  = 16'h0010; tick();
      in_vld  = 1'b0;
      drain();

`ifdef ONEHOT_TO_BINARY_ERR_CNT_EN
      lat_chk = 1'b0;
      in_vld  = 1'b1;
      in_vec  = 16'h0003;
      for (int k = 0; k < 300; k++) tick();
      in_vld = 1'b0;
      drain();
      for (int m = 0; m < 3; m++) chk($sformatf("cnt_sat_m%0d", m), cnt_o[m], 255);
      in_vld = 1'b1; tick();
      in_vld = 1'b0; tick();
      for (int m = 0; m < 3; m++) chk($sformatf("clr_setup_vld_m%0d", m), vld_o[m], 1);
      err_cnt_clr = 1'b1; tick();
      err_cnt_clr = 1'b0;
      for (int m = 0; m < 3; m++) chk($sformatf("cnt_clr_m%0d", m), cnt_o[m], 0);
      in_vld = 1'b1; tick();
      in_vld = 1'b0;
      drain();
      for (int m = 0; m < 3; m++) chk($sformatf("cnt_after_clr_m%0d", m), cnt_o[m], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
